approx_cache_ctrl: RTL and testbench

Parametrised direct-mapped, one-word-per-line cache controller for the memory subsystem, placed between the CPU-side request port and main memory.
Supports an approximate-transfer mode: when selected, data moved between cache and memory has its low APPROX_BITS bits forced to zero.
Write-through, no-write-allocate.
Both sides use valid/ready handshakes, and the block keeps hit/miss statistics counters.

---
 rtl/approx_cache_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_approx_cache_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate cache controller
// with an optional approximate-transfer mode that clears the data LSBs moved to or from
// memory. Keeps saturating hit and miss counters.
module approx_cache_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LINES       = 16,
  parameter int unsigned APPROX_BITS = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_wr_en,
  input  logic              cpu_approx,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_miss,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W;
  localparam logic [DATA_W-1:0] APPROX_MASK =
    {{(DATA_W - APPROX_BITS){1'b1}}, {APPROX_BITS{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StMemRd,
    StMemWait,
    StMemWr,
    StResp
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              approx_q;
  logic              hit_q;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              lookup_hit;
  logic [DATA_W-1:0] wdata_x;
  logic [DATA_W-1:0] rdata_x;
  logic              fill_en;
  logic              wr_hit_en;

  // Decode the latched request and apply the approximate mask on both transfer paths.
  always_comb begin
    idx        = addr_q[IDX_W-1:0];
    tag        = addr_q[ADDR_W-1:IDX_W];
    lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
    wdata_x    = approx_q ? (wdata_q & APPROX_MASK) : wdata_q;
    rdata_x    = approx_q ? (mem_rdata & APPROX_MASK) : mem_rdata;
    fill_en    = (state_q == StMemWait) && mem_resp_valid;
    wr_hit_en  = (state_q == StLookup) && wr_q && lookup_hit;
  end

  // Tag/data storage; no reset needed because valid_q gates every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= rdata_x;
    end else if (wr_hit_en) begin
      data_q[idx] <= wdata_x;
    end
  end

  // Control FSM with registered outputs, valid bits and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      valid_q        <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wr_q           <= 1'b0;
      approx_q       <= 1'b0;
      hit_q          <= 1'b0;
      hit_count      <= '0;
      miss_count     <= '0;
      cpu_req_ready  <= 1'b1;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      cpu_miss       <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
    end else begin
      // Response strobe lasts only for the single cycle spent in StResp.
      cpu_resp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req_valid) begin
            addr_q        <= cpu_addr;
            wdata_q       <= cpu_wdata;
            wr_q          <= cpu_wr_en;
            approx_q      <= cpu_approx;
            cpu_req_ready <= 1'b0;
            state_q       <= StLookup;
          end
        end
        StLookup: begin
          hit_q <= lookup_hit;
          if (lookup_hit) begin
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
          end
          if (wr_q) begin
            mem_req_valid <= 1'b1;
            mem_wr_en     <= 1'b1;
            mem_addr      <= addr_q;
            mem_wdata     <= wdata_x;
            state_q       <= StMemWr;
          end else if (lookup_hit) begin
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= data_q[idx];
            cpu_miss       <= 1'b0;
            state_q        <= StResp;
          end else begin
            mem_req_valid <= 1'b1;
            mem_wr_en     <= 1'b0;
            mem_addr      <= addr_q;
            state_q       <= StMemRd;
          end
        end
        StMemRd: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_q       <= StMemWait;
          end
        end
        StMemWait: begin
          if (mem_resp_valid) begin
            valid_q[idx]   <= 1'b1;
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= rdata_x;
            cpu_miss       <= 1'b1;
            state_q        <= StResp;
          end
        end
        StMemWr: begin
          if (mem_req_ready) begin
            mem_req_valid  <= 1'b0;
            mem_wr_en      <= 1'b0;
            cpu_resp_valid <= 1'b1;
            cpu_rdata      <= '0;
            cpu_miss       <= !hit_q;
            state_q        <= StResp;
          end
        end
        StResp: begin
          cpu_req_ready <= 1'b1;
          state_q       <= StIdle;
        end
        default: begin
          cpu_req_ready <= 1'b1;
          state_q       <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_approx_cache_ctrl.sv
// Self-checking bench for approx_cache_ctrl: directed scenarios followed by random
// traffic, all checked against a line-level cache model and a behavioural memory.
module tb_approx_cache_ctrl;

  localparam int unsigned LINES = 16;
  localparam int unsigned AB    = 8;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic        cpu_wr_en = 1'b0;
  logic        cpu_approx = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_miss;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  approx_cache_ctrl #(
    .ADDR_W(32), .DATA_W(32), .LINES(LINES), .APPROX_BITS(AB), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_wr_en(cpu_wr_en), .cpu_approx(cpu_approx), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
    .cpu_miss(cpu_miss), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } mreq_t;

  // Environment state: memory contents and a log of granted memory requests.
  logic [31:0] mem [logic [31:0]];
  mreq_t       mlog [$];
  int          stall_cfg = 0;
  int          stall_cnt = 0;
  bit          hold_resp = 0;
  int          inj_req = 0;
  int          inj_seen = 0;
  bit          pend_rd = 0;
  logic [31:0] pend_addr = '0;

  // Reference cache: which full address each line holds and the stored word.
  bit          m_vld  [LINES];
  logic [31:0] m_addr [LINES];
  logic [31:0] m_data [LINES];
  int          m_hits, m_misses;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] memv(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    if (a == 32'd6) return 32'h12345678;
    if (a == 32'd64) return 32'hDEADBEEF;
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  function automatic logic [31:0] amask(input logic [31:0] x);
    return (x >> AB) << AB;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: optional stall before grant, read data one cycle after grant.
  always @(negedge clk) begin
    mem_resp_valid = 1'b0;
    if (pend_rd || (inj_seen != inj_req)) begin
      mem_resp_valid = 1'b1;
      mem_rdata      = memv(pend_addr);
      pend_rd        = 1'b0;
      inj_seen       = inj_req;
    end
    mem_req_ready = 1'b0;
    if (mem_req_valid) begin
      if (stall_cnt < stall_cfg) begin
        stall_cnt++;
      end else begin
        stall_cnt     = 0;
        mem_req_ready = 1'b1;
        mlog.push_back('{wr: mem_wr_en, addr: mem_addr, data: mem_wdata});
        if (mem_wr_en) mem[mem_addr] = mem_wdata;
        else if (!hold_resp) begin
          pend_rd   = 1'b1;
          pend_addr = mem_addr;
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_vld[i] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_req_ready", 32'(cpu_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
  endtask

  task automatic start_req(input bit wr, input bit ap, input logic [31:0] addr,
                           input logic [31:0] wdata);
    @(negedge clk);
    chk("req_ready_idle", 32'(cpu_req_ready), 32'd1);
    cpu_req_valid = 1'b1;
    cpu_wr_en     = wr;
    cpu_approx    = ap;
    cpu_addr      = addr;
    cpu_wdata     = wdata;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
  endtask

  // Count cycles after the accepting edge until the response strobe (bounded).
  task automatic wait_resp(output logic [31:0] rd, output logic miss, output int lat);
    bit got = 0;
    rd = '0; miss = 1'b0; lat = 0;
    for (int k = 1; k <= 60 && !got; k++) begin
      @(negedge clk);
      if (cpu_resp_valid) begin
        got = 1; lat = k; rd = cpu_rdata; miss = cpu_miss;
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
  endtask

  // Hold mem_req_ready low for stall_cfg cycles while checking the request is stable and
  // that a second CPU request is refused.
  task automatic stall_checks(input logic [31:0] addr);
    bit seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = mem_req_valid;
    end
    chk("stall_req_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_req_valid", 32'(mem_req_valid), 32'd1);
      chk("stall_addr", mem_addr, addr);
      chk("stall_wr_en", 32'(mem_wr_en), 32'd0);
      chk("stall_cpu_ready", 32'(cpu_req_ready), 32'd0);
      cpu_req_valid = (i < 4);
      cpu_addr      = addr + 32'd16;
    end
  endtask

  task automatic do_xact(input bit wr, input bit ap, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit stall_chk,
                         output logic [31:0] rd, output logic miss, output int lat);
    int          idx, base;
    bit          hit, exp_mem, exp_mwr;
    logic [31:0] exp_rd, exp_mdata, v;
    bit          exp_miss;
    idx = int'(addr % LINES);
    hit = m_vld[idx] && (m_addr[idx] == addr);
    if (hit) m_hits = (m_hits < CMAX) ? m_hits + 1 : CMAX;
    else m_misses = (m_misses < CMAX) ? m_misses + 1 : CMAX;
    exp_mem = 1; exp_mwr = 0; exp_mdata = '0;
    if (wr) begin
      v = ap ? amask(wdata) : wdata;
      if (hit) m_data[idx] = v;
      exp_rd = '0; exp_miss = !hit; exp_mwr = 1; exp_mdata = v;
    end else if (hit) begin
      exp_rd = m_data[idx]; exp_miss = 0; exp_mem = 0;
    end else begin
      v = ap ? amask(memv(addr)) : memv(addr);
      m_vld[idx] = 1; m_addr[idx] = addr; m_data[idx] = v;
      exp_rd = v; exp_miss = 1;
    end
    base = mlog.size();
    start_req(wr, ap, addr, wdata);
    if (stall_chk) stall_checks(addr);
    wait_resp(rd, miss, lat);
    chk("rdata", rd, exp_rd);
    chk("miss", 32'(miss), 32'(exp_miss));
    chk("hit_count", 32'(hit_count), m_hits);
    chk("miss_count", 32'(miss_count), m_misses);
    chk("mem_req_num", mlog.size() - base, 32'(exp_mem));
    if (exp_mem && mlog.size() > base) begin
      chk("mem_wr_en", 32'(mlog[base].wr), 32'(exp_mwr));
      chk("mem_addr", mlog[base].addr, addr);
      if (exp_mwr) chk("mem_wdata", mlog[base].data, exp_mdata);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        miss;
    int          lat;
    bit          seen;

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("init_req_ready", 32'(cpu_req_ready), 32'd1);
    chk("init_rdata", cpu_rdata, 32'd0);
    chk("init_miss", 32'(cpu_miss), 32'd0);
    chk("init_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("init_mem_addr", mem_addr, 32'd0);
    chk("init_mem_wdata", mem_wdata, 32'd0);
    do_reset();

    // Read miss then read hit of addr 6.
    do_xact(0, 0, 32'd6, 32'd0, 0, rd, miss, lat);
    chk("t1_miss_rdata", rd, 32'h12345678);
    do_xact(0, 0, 32'd6, 32'd0, 0, rd, miss, lat);
    chk("t1_hit_miss", 32'(miss), 32'd0);
    chk("t1_hit_latency", lat, 32'd2);
    chk("t1_hits", 32'(hit_count), 32'd1);
    chk("t1_misses", 32'(miss_count), 32'd1);

    // Approximate fill, exact re-read hits the masked word.
    do_xact(0, 1, 32'd64, 32'd0, 0, rd, miss, lat);
    chk("t2_approx_rdata", rd, 32'hDEADBE00);
    do_xact(0, 0, 32'd64, 32'd0, 0, rd, miss, lat);
    chk("t2_reread", rd, 32'hDEADBE00);
    chk("t2_reread_miss", 32'(miss), 32'd0);

    // Conflict misses on index 1.
    do_reset();
    do_xact(0, 0, 32'd1, 32'd0, 0, rd, miss, lat);
    do_xact(0, 0, 32'd17, 32'd0, 0, rd, miss, lat);
    do_xact(0, 0, 32'd1, 32'd0, 0, rd, miss, lat);
    chk("t3_misses", 32'(miss_count), 32'd3);

    // Write hit, read back, write miss without allocation.
    do_xact(0, 0, 32'd1, 32'd0, 0, rd, miss, lat);
    do_xact(1, 0, 32'd1, 32'd255, 0, rd, miss, lat);
    chk("t4_wr_hit_miss", 32'(miss), 32'd0);
    do_xact(0, 0, 32'd1, 32'd0, 0, rd, miss, lat);
    chk("t4_readback", rd, 32'd255);
    do_xact(1, 0, 32'd9, 32'd15, 0, rd, miss, lat);
    chk("t4_wr_miss", 32'(miss), 32'd1);
    do_xact(0, 0, 32'd9, 32'd0, 0, rd, miss, lat);
    chk("t4_rd9_miss", 32'(miss), 32'd1);

    // Memory stall with a refused concurrent CPU request.
    stall_cfg = 5;
    do_xact(0, 0, 32'd1000, 32'd0, 1, rd, miss, lat);
    stall_cfg = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_extra_resp", 32'(cpu_resp_valid), 32'd0);
      chk("t5_idle_ready", 32'(cpu_req_ready), 32'd1);
    end

    // Miss counter saturation through conflict misses.
    do_reset();
    for (int i = 0; i < 20; i++) do_xact(0, 0, (i % 2 == 0) ? 32'd3 : 32'd19, 32'd0, 0,
                                         rd, miss, lat);
    chk("t5_miss_sat", 32'(miss_count), 32'd15);

    // Reset while waiting for read data; late response must be ignored.
    do_reset();
    do_xact(0, 0, 32'd6, 32'd0, 0, rd, miss, lat);
    hold_resp = 1;
    start_req(0, 0, 32'd22, 32'd0);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = mem_req_valid;
    end
    chk("t6_req_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("t6_in_wait", 32'(mem_req_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("t6_ready", 32'(cpu_req_ready), 32'd1);
    chk("t6_hits", 32'(hit_count), 32'd0);
    chk("t6_misses", 32'(miss_count), 32'd0);
    inj_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_late_resp_ignored", 32'(cpu_resp_valid), 32'd0);
      chk("t6_still_idle", 32'(cpu_req_ready), 32'd1);
    end
    hold_resp = 0;
    do_xact(0, 0, 32'd6, 32'd0, 0, rd, miss, lat);
    chk("t6_rd6_miss", 32'(miss), 32'd1);

    // Random traffic over a few conflicting tags.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      do_xact(($urandom % 3) == 0, $urandom % 2, 32'($urandom_range(0, 39)), $urandom, 0,
              rd, miss, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
